// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port (A = CPU, B = DMA) arbiter in front of a 1024x32
// single-port word memory with combinational read data.
// Grants are combinational and the access completes at the next posedge.
// Read data is registered, so there is one cycle of read latency.
// On conflict the arbiter uses round-robin against a last-granted pointer.
// Define DM_ARB_FIXED_PRIO_EN to make port A always win a conflict instead.
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt.
// A cycle with gnt high is one completed access. Dropping req before gnt
// withdraws the request and leaves no side effect.
module dm_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [11:2] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [11:2] b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout
);

    typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

    ptr_e        last_q, last_d;
    logic        a_rvalid_q, a_rvalid_d;
    logic        b_rvalid_q, b_rvalid_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            a_gnt = a_req;
            b_gnt = b_req & ~a_req;
`else
            if (a_req && b_req) begin
                a_gnt = (last_q == PTR_B);
                b_gnt = (last_q == PTR_A);
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
`endif
        end
    end

    // Memory-side mux: the granted port, else the last-granted port's values.
    always_comb begin
        mem_addr = a_addr;
        mem_din  = a_wdata;
        mem_we   = 1'b0;
        if (a_gnt) begin
            mem_addr = a_addr;
            mem_din  = a_wdata;
            mem_we   = a_we;
        end else if (b_gnt) begin
            mem_addr = b_addr;
            mem_din  = b_wdata;
            mem_we   = b_we;
        end else if (last_q == PTR_B) begin
            mem_addr = b_addr;
            mem_din  = b_wdata;
        end
    end

    // Next-state: pointer follows the active grant, reads capture mem_dout.
    always_comb begin
        last_d     = last_q;
        a_rvalid_d = a_gnt & ~a_we;
        b_rvalid_d = b_gnt & ~b_we;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        if (a_gnt) begin
            last_d = PTR_A;
        end else if (b_gnt) begin
            last_d = PTR_B;
        end
        if (a_gnt && !a_we) begin
            a_rdata_d = mem_dout;
        end
        if (b_gnt && !b_we) begin
            b_rdata_d = mem_dout;
        end
    end

    // State registers; reset points at B so A wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= PTR_B;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= 32'h0;
            b_rdata_q  <= 32'h0;
        end else begin
            last_q     <= last_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter: a 1024x32 memory model behind the arbiter,
// scenario tasks with inline checks, and per-port read-data scoreboards
// filled when a read is issued and drained when rvalid is seen.
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [11:2] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] a_exp_q[$];
  logic [31:0] b_exp_q[$];
  int          n_checks;
  int          n_pass;

  dm_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .a_rdata  (a_rdata),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write at posedge
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // scoreboard: every rvalid must match the oldest expected read data
  always @(negedge clk) begin
    if (rst_n === 1'b1 && a_rvalid === 1'b1) begin
      n_checks++;
      if (a_exp_q.size() == 0) begin
        $display("FAIL sb_a_unexpected: a_rvalid=1 rdata=%h, no read pending", a_rdata);
      end else begin
        logic [31:0] e;
        e = a_exp_q.pop_front();
        if (a_rdata !== e) $display("FAIL sb_a_rdata: got %h expected %h", a_rdata, e);
        else n_pass++;
      end
    end
    if (rst_n === 1'b1 && b_rvalid === 1'b1) begin
      n_checks++;
      if (b_exp_q.size() == 0) begin
        $display("FAIL sb_b_unexpected: b_rvalid=1 rdata=%h, no read pending", b_rdata);
      end else begin
        logic [31:0] e;
        e = b_exp_q.pop_front();
        if (b_rdata !== e) $display("FAIL sb_b_rdata: got %h expected %h", b_rdata, e);
        else n_pass++;
      end
    end
  end

  // driver helpers
  task automatic drive_idle();
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; b_req = 1'b1; b_we = 1'b1;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, mem_we} !== 3'b000)
      $display("FAIL rst_gnt_we: gnt_a/gnt_b/we=%b expected 000", {a_gnt, b_gnt, mem_we});
    else n_pass++;
    n_checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00 || a_rdata !== 32'h0 || b_rdata !== 32'h0)
      $display("FAIL rst_outputs: rvalid=%b a_rdata=%h b_rdata=%h expected 00/0/0",
               {a_rvalid, b_rvalid}, a_rdata, b_rdata);
    else n_pass++;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // A write 0x005 then read-after-write on the next cycle
  task automatic test_write_read();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 10'h005; a_wdata = 32'hDEADBEEF;
    ref_mem[10'h005] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h005 || mem_din !== 32'hDEADBEEF)
      $display("FAIL wr_access: gnt=%b we=%b addr=%h din=%h expected 1 1 005 deadbeef",
               a_gnt, mem_we, mem_addr, mem_din);
    else n_pass++;
    @(negedge clk);
    a_we = 1'b0;
    a_exp_q.push_back(ref_mem[10'h005]);
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL rd_access: gnt=%b we=%b expected 1 0", a_gnt, mem_we);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF)
      $display("FAIL raw_rdata: rvalid=%b rdata=%h expected 1 deadbeef", a_rvalid, a_rdata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF)
      $display("FAIL rvalid_pulse: rvalid=%b rdata=%h expected 0 deadbeef (held)", a_rvalid, a_rdata);
    else n_pass++;
  endtask

  // both ports request for 4 cycles right after reset
  task automatic test_conflict();
    logic exp_a, prev_a;
    apply_reset();
    prev_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 10'h00A;
      b_req = 1'b1; b_we = 1'b0; b_addr = 10'h014;
`ifdef DM_ARB_FIXED_PRIO_EN
      exp_a = 1'b1;
`else
      exp_a = (k % 2 == 0);
`endif
      if (exp_a) a_exp_q.push_back(ref_mem[10'h00A]);
      else       b_exp_q.push_back(ref_mem[10'h014]);
      #1;
      n_checks++;
      if (a_gnt !== exp_a || b_gnt !== ~exp_a)
        $display("FAIL conflict_gnt[%0d]: a_gnt=%b b_gnt=%b expected %b %b", k, a_gnt, b_gnt, exp_a, ~exp_a);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (a_rvalid !== prev_a || b_rvalid !== ~prev_a)
          $display("FAIL conflict_rvalid[%0d]: a=%b b=%b expected %b %b", k, a_rvalid, b_rvalid, prev_a, ~prev_a);
        else n_pass++;
      end
      prev_a = exp_a;
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (a_rvalid !== prev_a || b_rvalid !== ~prev_a)
      $display("FAIL conflict_rvalid_last: a=%b b=%b expected %b %b", a_rvalid, b_rvalid, prev_a, ~prev_a);
    else n_pass++;
    @(negedge clk);
  endtask

  // B alone: write 0x3FF, read it back, A stays silent
  task automatic test_b_only();
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h3FF; b_wdata = 32'h12345678;
    ref_mem[10'h3FF] = 32'h12345678;
    #1;
    n_checks++;
    if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'h3FF)
      $display("FAIL b_write: b_gnt=%b a_gnt=%b we=%b addr=%h expected 1 0 1 3ff", b_gnt, a_gnt, mem_we, mem_addr);
    else n_pass++;
    @(negedge clk);
    b_we = 1'b0;
    b_exp_q.push_back(ref_mem[10'h3FF]);
    #1;
    n_checks++;
    if (b_rvalid !== 1'b0)
      $display("FAIL b_write_norvalid: b_rvalid=%b expected 0", b_rvalid);
    else n_pass++;
    @(negedge clk);
    b_req = 1'b0; a_addr = 10'h111;
    #1;
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h12345678 || a_rvalid !== 1'b0)
      $display("FAIL b_read: b_rvalid=%b b_rdata=%h a_rvalid=%b expected 1 12345678 0",
               b_rvalid, b_rdata, a_rvalid);
    else n_pass++;
    n_checks++;
    if (mem_addr !== 10'h3FF || mem_we !== 1'b0)
      $display("FAIL idle_mux: mem_addr=%h we=%b expected 3ff 0 (last-granted B)", mem_addr, mem_we);
    else n_pass++;
    @(negedge clk);
    drive_idle();
  endtask

  // B raises a write request and withdraws it while A is being served
  task automatic test_cancel();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h01E;
    b_req = 1'b1; b_we = 1'b1; b_addr = 10'h028; b_wdata = 32'hBAD0BAD0;
    a_exp_q.push_back(ref_mem[10'h01E]);
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'h01E)
      $display("FAIL cancel_gnt: a_gnt=%b b_gnt=%b we=%b addr=%h expected 1 0 0 01e",
               a_gnt, b_gnt, mem_we, mem_addr);
    else n_pass++;
    @(negedge clk);
    b_req = 1'b0;
    a_addr = 10'h028;
    a_exp_q.push_back(ref_mem[10'h028]);
    #1;
    n_checks++;
    if (b_gnt !== 1'b0 || b_rvalid !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL cancel_noaccess: b_gnt=%b b_rvalid=%b we=%b expected 0 0 0", b_gnt, b_rvalid, mem_we);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if (a_rdata !== ref_mem[10'h028] || b_rvalid !== 1'b0)
      $display("FAIL cancel_mem: a_rdata=%h b_rvalid=%b expected %h 0", a_rdata, b_rvalid, ref_mem[10'h028]);
    else n_pass++;
    @(negedge clk);
  endtask

  // reset asserted just after an A read grant completes
  task automatic test_reset_mid();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h005;
    #1;
    n_checks++;
    if (a_gnt !== 1'b1)
      $display("FAIL rmid_gnt: a_gnt=%b expected 1", a_gnt);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    n_checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h0)
      $display("FAIL rmid_during: a_rvalid=%b a_rdata=%h expected 0 0", a_rvalid, a_rdata);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'h0)
      $display("FAIL rmid_after: a_rvalid=%b a_rdata=%h expected 0 0", a_rvalid, a_rdata);
    else n_pass++;
    a_req = 1'b1; a_we = 1'b0; a_addr = 10'h007;
    b_req = 1'b1; b_we = 1'b0; b_addr = 10'h008;
    a_exp_q.push_back(ref_mem[10'h007]);
    #1;
    n_checks++;
    if (a_gnt !== 1'b1 || b_gnt !== 1'b0)
      $display("FAIL rmid_conflict: a_gnt=%b b_gnt=%b expected 1 0", a_gnt, b_gnt);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive_idle();
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_write_read();
    test_conflict();
    test_b_only();
    test_cancel();
    test_reset_mid();

    repeat (2) @(negedge clk);
    n_checks++;
    if (a_exp_q.size() != 0 || b_exp_q.size() != 0)
      $display("FAIL sb_drain: pending a=%0d b=%0d expected 0 0", a_exp_q.size(), b_exp_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on posedge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: a_req / b_req  input  1  access request from port A (CPU) / port B (DMA).
REQ-004 SHALL have ports: a_we / b_we  input  1  request is a write (1) or read (0).
REQ-005 SHALL have ports: a_addr / b_addr  input  10 ([11:2])  word address.
REQ-006 SHALL have ports: a_wdata / b_wdata  input  32  write data.
REQ-007 SHALL have ports: a_gnt / b_gnt  output  1  combinational grant; the access completes at the next posedge.
REQ-008 SHALL have ports: a_rvalid / b_rvalid  output  1  registered read-data-valid pulse.
REQ-009 SHALL have ports: a_rdata / b_rdata  output  32  registered read data.
REQ-010 SHALL have ports: mem_addr  output  10; mem_din  output  32; mem_we  output  1; mem_dout  input  32 (combinational read data from the 1024x32 word memory).

Function
REQ-011 SHALL assert at most one of a_gnt, b_gnt in any cycle.
REQ-012 SHALL grant only a requesting port: x_gnt implies x_req.
REQ-013 SHALL grant the sole requester when exactly one x_req is high, in the same cycle.
REQ-014 SHALL, when both request, grant the port opposite to the last-granted pointer (round-robin).
REQ-015 SHALL update the last-granted pointer at each posedge where a grant is active; no grant leaves it unchanged.
REQ-016 SHALL drive mem_addr/mem_din from the granted port's addr/wdata; with no grant, drive the last-granted port's values.
REQ-017 SHALL drive mem_we = granted port's we AND gnt; mem_we SHALL be 0 with no grant.
REQ-018 SHALL, on a granted read, capture mem_dout into x_rdata at that posedge and pulse x_rvalid high for exactly the following cycle (read latency 1).
REQ-019 SHALL not pulse x_rvalid on granted writes; x_rdata SHALL hold its value until the next granted read by the same port.
REQ-020 SHALL require each requester to hold req/we/addr/wdata stable until gnt is seen; dropping req before gnt is legal and cancels the request with no side effects.
REQ-021 SHALL support back-to-back grants to the same port on consecutive cycles when the other port is idle.
REQ-022 SHALL, with both ports requesting continuously, alternate grants A,B,A,B,... with no idle cycle.
REQ-023 SHALL deliver the new data to a read that follows a write to the same address in the next cycle, because the memory write commits at the earlier posedge.

Reset
REQ-024 SHALL on rst_n low, asynchronously and immediately: a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, last-granted pointer=B (so A wins the first conflict).
REQ-025 SHALL hold mem_we=0 and both gnt=0 while rst_n is low.
REQ-026 SHALL drop an in-flight read on reset mid-operation: no rvalid pulse after rst_n deasserts for a grant issued before reset.

Configuration
REQ-027 SHALL support the macro DM_ARB_FIXED_PRIO_EN.
REQ-028 SHALL, with DM_ARB_FIXED_PRIO_EN defined, always grant A on conflict; the pointer SHALL be unused.
REQ-029 SHALL, with DM_ARB_FIXED_PRIO_EN undefined, use round-robin per REQ-014/015.

Verification
REQ-030 SHALL check: A write addr 0x005 data 0xDEADBEEF, then A read 0x005 -> mem_we=1 for 1 cycle; a_rvalid=1 the cycle after the read grant with a_rdata=0xDEADBEEF.
REQ-031 SHALL check: after reset, A and B both read for 4 cycles -> gnt order A,B,A,B; each rvalid occurs 1 cycle after its grant.
REQ-032 SHALL check: DM_ARB_FIXED_PRIO_EN defined, both request for 4 cycles -> a_gnt=1 every cycle, b_gnt=0.
REQ-033 SHALL check: B writes 0x3FF data 0x12345678 while A is idle; B then reads 0x3FF -> b_rdata=0x12345678; a_rvalid never asserts.
REQ-034 SHALL check: rst_n pulled low for 1 cycle right after an A read grant -> a_rvalid stays 0, a_rdata=0, the next conflict is granted to A.
REQ-035 SHALL check: B raises req, then drops it before a grant (A holding) -> no B access and no b_rvalid.
